alarm_ring_ctrl: RTL and testbench
==================================

# alarm_ring_ctrl

- Responder side of the alarm path: consumes the running clock digits and the user alarm setting, and decides when the alarm rings.
- Also handles snooze and dismiss, and drives the blinking alarm LED.
- Sits between the time-keeping counter, the button pulse detectors and the LED output.

## Interface
Parameters:
- CLK_HZ, 100000000, input clock frequency; sets the 1 s tick and the 0.5 s blink half-period.
- SNOOZE_MIN, 5, snooze length in minutes, legal range 1..9.
- MAX_SNOOZE, 3, snoozes allowed per alarm event; a further snooze request acts as dismiss.
- RING_SECS, 60, auto-timeout length in seconds; only used with the timeout feature (see Configuration).

Ports:
- clk  in  1  system clock; one clock domain only.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  alarm armed (level).
- HT, HU, MT, MU  in  4 each  running clock time, BCD, 24 h format.
- AHT, AHU, AMT, AMU  in  4 each  alarm setting, BCD; 00:00 means no alarm set.
- dismiss  in  1  one-cycle pulse from the centre button.
- snooze  in  1  one-cycle pulse, OR of the up/down/left/right buttons.
- ringing  out  1  alarm currently ringing (level).
- led_alarm  out  1  blinking LED; 1 only while ringing.
- snoozed  out  1  a snooze is pending.
- snooze_cnt  out  2  snoozes used in the current alarm event.
- THT, THU, TMT, TMU  out  4 each  active target time, BCD.

## Operation
- The FSM has three states: IDLE, RING and SNOOZE.
- Target time:
  - In IDLE, the target is the alarm digits.
  - In SNOOZE, the target is the snooze register.
- match = all four clock digits equal the four target digits.
- Trigger = rising edge of match, using a registered copy of match from the previous cycle. The alarm therefore rings once per matching minute, not for the whole minute.
- IDLE -> RING on a trigger, only when en=1 and the alarm setting is not 00:00. On entry, snooze_cnt is cleared.
- SNOOZE -> RING on a trigger.
- RING -> IDLE on dismiss. snooze_cnt is cleared.
- RING -> SNOOZE on snooze, when snooze_cnt < MAX_SNOOZE:
  - The snooze register is loaded with the current clock time + SNOOZE_MIN.
  - snooze_cnt is incremented.
- RING -> IDLE on snooze, when snooze_cnt == MAX_SNOOZE.
- SNOOZE -> IDLE when any alarm digit changes or on dismiss.
- Any state -> IDLE when en=0, checked before all other transitions.
- Snooze arithmetic, all in BCD:
  - MU + SNOOZE_MIN; a result above 9 subtracts 10 and carries into MT.
  - MT wraps 5 -> 0 and carries into the hour.
  - Hours wrap 23 -> 00; HT:HU = 1:9 -> 2:0.
  - Example: 23:58 + 5 = 00:03.
- Simultaneous dismiss and snooze in the same cycle: dismiss wins.
- Blink: phase toggles every CLK_HZ/2 cycles. Phase and divider are forced to 1 and 0 on entry to RING, so led_alarm = ringing AND phase.
- Reset (rst=0) mid-operation: FSM goes to IDLE at once (asynchronous) and all outputs take their reset values.

## Timing
- Reset values:
  - ringing=0, led_alarm=0, snoozed=0, snooze_cnt=0.
  - THT..TMU=0, snooze register=0, previous-match register=0.
  - Blink divider=0, seconds counter=0.
- Trigger latency: ringing and led_alarm go to 1 one clk after the cycle in which the clock digits first equal the target.
- Dismiss and snooze latency: ringing goes to 0 one clk after the pulse; snoozed goes to 1 in the same cycle.
- THT..TMU are registered and follow the state change with a delay of one cycle.
- en=0 drops ringing on the next clk edge.
- Alarm digits that change on the same cycle as a trigger: the trigger is evaluated against the previous target; no glitch filtering is done.

## Configuration
- Macro: ALARM_AUTO_TIMEOUT_EN.
- Defined:
  - A 1 s tick (CLK_HZ cycles) counts seconds spent in RING. The counter is cleared on entry to RING.
  - At RING_SECS the FSM goes RING -> IDLE and snooze_cnt is cleared.
  - The timeout is lower priority than dismiss and snooze in the same cycle.
- Undefined: RING persists until dismiss, snooze or en=0. The seconds counter and RING_SECS are not synthesised.

## Test plan
Bench parameters: CLK_HZ=20 so the blink half-period is 10 cycles.
- Alarm 07:30, en=1, clock steps 07:29 -> 07:30:
  - ringing=1 one cycle later.
  - led_alarm toggles every 10 cycles.
  - Holding 07:30 after dismiss gives no re-trigger.
- Alarm 23:58, clock 23:58, snooze pulse:
  - snoozed=1, target 00:03, snooze_cnt=1.
  - Clock stepped to 00:03 gives ringing=1.
- MAX_SNOOZE=3: three snooze/ring cycles, then a fourth snooze -> IDLE, snooze_cnt=0, ringing=0.
- dismiss and snooze in the same cycle while ringing -> IDLE, snoozed=0.
- Edge cases:
  - Alarm 00:00 with clock at 00:00: no ring.
  - en dropped while ringing: ringing=0 next cycle.
  - rst asserted mid-SNOOZE: all outputs 0 immediately.
- With ALARM_AUTO_TIMEOUT_EN and RING_SECS=2: ringing falls after 40 cycles with no button input. Without the macro: still ringing after 1000 cycles.

Source files
------------

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring controller: trigger on a minute match, snooze/dismiss handling, blinking LED.
// Optional ALARM_AUTO_TIMEOUT_EN adds a RING_SECS auto-timeout while ringing.
module alarm_ring_ctrl #(
  parameter int CLK_HZ     = 100000000,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3,
  parameter int RING_SECS  = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] HT,
  input  logic [3:0] HU,
  input  logic [3:0] MT,
  input  logic [3:0] MU,
  input  logic [3:0] AHT,
  input  logic [3:0] AHU,
  input  logic [3:0] AMT,
  input  logic [3:0] AMU,
  input  logic       dismiss,
  input  logic       snooze,
  output logic       ringing,
  output logic       led_alarm,
  output logic       snoozed,
  output logic [1:0] snooze_cnt,
  output logic [3:0] THT,
  output logic [3:0] THU,
  output logic [3:0] TMT,
  output logic [3:0] TMU
);

  localparam int HALF = CLK_HZ / 2;
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
  localparam logic [1:0] MAX_CNT = 2'(MAX_SNOOZE);

  if (SNOOZE_MIN < 1 || SNOOZE_MIN > 9 || MAX_SNOOZE > 3 || RING_SECS < 1 || CLK_HZ < 2) begin : g_bad_param
    $error("alarm_ring_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1, SNOOZE = 2'd2} state_t;

  state_t           state_r, state_s;
  logic [15:0]      tgt_r, snz_r, snz_s, alarm_prev_r, clk_s, alarm_s, cmp_s;
  logic [1:0]       cnt_r, cnt_s;
  logic             match_s, match_prev_r, trig_s, enter_s, timeout_s;
  logic             phase_r, phase_s;
  logic [DIV_W-1:0] div_r, div_s;
  logic             ringing_r, led_r, snoozed_r;

  // BCD time + SNOOZE_MIN minutes with minute/hour carries and 23:59 -> 00:00 wrap
  function automatic logic [15:0] bcd_add_min(input logic [15:0] t);
    logic [4:0] mu, mt;
    logic [3:0] ht, hu;
    logic       c;
    mu = {1'b0, t[3:0]} + 5'(SNOOZE_MIN);
    if (mu > 5'd9) begin
      mu = mu - 5'd10;
      c  = 1'b1;
    end else begin
      c  = 1'b0;
    end
    mt = {1'b0, t[7:4]} + {4'd0, c};
    if (mt > 5'd5) begin
      mt = 5'd0;
      c  = 1'b1;
    end else begin
      c  = 1'b0;
    end
    ht = t[15:12];
    hu = t[11:8];
    if (c) begin
      if (ht == 4'd2 && hu == 4'd3) begin
        ht = 4'd0;
        hu = 4'd0;
      end else if (hu == 4'd9) begin
        ht = ht + 4'd1;
        hu = 4'd0;
      end else begin
        hu = hu + 4'd1;
      end
    end
    return {ht, hu, mt[3:0], mu[3:0]};
  endfunction

`ifdef ALARM_AUTO_TIMEOUT_EN
  localparam int TICK_W = $clog2(CLK_HZ);
  localparam int SEC_W  = $clog2(RING_SECS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_HZ - 1);
  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(RING_SECS - 1);
  logic [TICK_W-1:0] tick_r;
  logic [SEC_W-1:0]  sec_r;

  // Seconds spent ringing, restarted on every entry to RING
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_r <= '0;
      sec_r  <= '0;
    end else if (enter_s) begin
      tick_r <= '0;
      sec_r  <= '0;
    end else if (state_r == RING) begin
      if (tick_r == TICK_LAST) begin
        tick_r <= '0;
        sec_r  <= sec_r + SEC_W'(1);
      end else begin
        tick_r <= tick_r + TICK_W'(1);
      end
    end
  end
`endif

  // Match against the previous cycle's target so same-cycle alarm edits cannot glitch a trigger
  always_comb begin
    clk_s   = {HT, HU, MT, MU};
    alarm_s = {AHT, AHU, AMT, AMU};
    cmp_s   = (state_r == SNOOZE) ? snz_r : alarm_prev_r;
    match_s = (clk_s == cmp_s);
    trig_s  = match_s & ~match_prev_r;
`ifdef ALARM_AUTO_TIMEOUT_EN
    timeout_s = (state_r == RING) && (tick_r == TICK_LAST) && (sec_r == SEC_LAST);
`else
    timeout_s = 1'b0;
`endif
  end

  // Next state, snooze bookkeeping and blink phase
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    snz_s   = snz_r;
    if (!en) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (trig_s && alarm_prev_r != 16'd0) state_s = RING;
          else                                 state_s = IDLE;
        end
        RING: begin
          if (dismiss) begin
            state_s = IDLE;
          end else if (snooze) begin
            if (cnt_r < MAX_CNT) begin
              state_s = SNOOZE;
              snz_s   = bcd_add_min(clk_s);
              cnt_s   = cnt_r + 2'd1;
            end else begin
              state_s = IDLE;
            end
          end else if (timeout_s) begin
            state_s = IDLE;
          end else begin
            state_s = RING;
          end
        end
        SNOOZE: begin
          if (alarm_s != alarm_prev_r || dismiss) state_s = IDLE;
          else if (trig_s)                        state_s = RING;
          else                                    state_s = SNOOZE;
        end
        default: state_s = IDLE;
      endcase
    end
    if (state_s == IDLE) cnt_s = 2'd0;
    else                 cnt_s = cnt_s;

    enter_s = (state_s == RING) && (state_r != RING);
    if (enter_s) begin
      phase_s = 1'b1;
      div_s   = '0;
    end else if (state_r == RING) begin
      if (div_r == DIV_LAST) begin
        phase_s = ~phase_r;
        div_s   = '0;
      end else begin
        phase_s = phase_r;
        div_s   = div_r + DIV_W'(1);
      end
    end else begin
      phase_s = phase_r;
      div_s   = '0;
    end
  end

  // State, history and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      tgt_r        <= 16'd0;
      snz_r        <= 16'd0;
      alarm_prev_r <= 16'd0;
      cnt_r        <= 2'd0;
      match_prev_r <= 1'b0;
      phase_r      <= 1'b0;
      div_r        <= '0;
      ringing_r    <= 1'b0;
      led_r        <= 1'b0;
      snoozed_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      tgt_r        <= (state_r == SNOOZE) ? snz_r : alarm_s;
      snz_r        <= snz_s;
      alarm_prev_r <= alarm_s;
      cnt_r        <= cnt_s;
      match_prev_r <= match_s;
      phase_r      <= phase_s;
      div_r        <= div_s;
      ringing_r    <= (state_s == RING);
      led_r        <= (state_s == RING) & phase_s;
      snoozed_r    <= (state_s == SNOOZE);
    end
  end

  assign ringing    = ringing_r;
  assign led_alarm  = led_r;
  assign snoozed    = snoozed_r;
  assign snooze_cnt = cnt_r;
  assign {THT, THU, TMT, TMU} = tgt_r;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Self-checking bench for alarm_ring_ctrl: directed steps plus randomized alarm/snooze rounds
// checked against a minutes-of-day reference model.
module tb_alarm_ring_ctrl;

  localparam int CLK_HZ = 20;
  localparam int SNZ    = 5;
  localparam int MAXS   = 3;

  logic       clk = 1'b0;
  logic       rst, en, dismiss, snooze;
  logic [3:0] HT, HU, MT, MU, AHT, AHU, AMT, AMU;
  logic       ringing, led_alarm, snoozed;
  logic [1:0] snooze_cnt;
  logic [3:0] THT, THU, TMT, TMU;

  int n_chk = 0;
  int n_err = 0;

  alarm_ring_ctrl #(.CLK_HZ(CLK_HZ), .SNOOZE_MIN(SNZ), .MAX_SNOOZE(MAXS), .RING_SECS(2)) dut (
    .clk(clk), .rst(rst), .en(en),
    .HT(HT), .HU(HU), .MT(MT), .MU(MU),
    .AHT(AHT), .AHU(AHU), .AMT(AMT), .AMU(AMU),
    .dismiss(dismiss), .snooze(snooze),
    .ringing(ringing), .led_alarm(led_alarm), .snoozed(snoozed), .snooze_cnt(snooze_cnt),
    .THT(THT), .THU(THU), .TMT(TMT), .TMU(TMU)
  );

  always #5 clk = ~clk;

  // Reference: minutes-of-day -> BCD hh:mm digits
  function automatic logic [15:0] bcd(input int m);
    int h, mm;
    h  = m / 60;
    mm = m % 60;
    return {4'(h / 10), 4'(h % 10), 4'(mm / 10), 4'(mm % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_clk(input int m);
    {HT, HU, MT, MU} = bcd(m);
  endtask

  task automatic set_alm(input int m);
    {AHT, AHU, AMT, AMU} = bcd(m);
  endtask

  task automatic setup(input int alm, input int tim);
    en = 1'b0;
    set_alm(alm);
    set_clk(tim);
    repeat (3) tick();
    en = 1'b1;
    tick();
  endtask

  task automatic pulse(input logic d, input logic s);
    dismiss = d;
    snooze  = s;
    tick();
    dismiss = 1'b0;
    snooze  = 1'b0;
  endtask

  // Ring window model: LED high for k/10 even, ringing drops at drop_at (negative = never)
  task automatic ring_window(input int n, input int drop_at);
    logic er;
    for (int k = 1; k <= n; k++) begin
      tick();
      er = (drop_at < 0) || (k < drop_at);
      chk("ring_hold", 32'(ringing), 32'(er));
      chk("led_blink", 32'(led_alarm), 32'(er && ((k / 10) % 2 == 0)));
    end
  endtask

  initial begin
    int cur, a, drop;
    rst = 1'b0; en = 1'b0; dismiss = 1'b0; snooze = 1'b0;
    set_clk(0); set_alm(0);
    #3;
    chk("rst_ringing", 32'(ringing), 32'd0);
    chk("rst_led", 32'(led_alarm), 32'd0);
    chk("rst_snoozed", 32'(snoozed), 32'd0);
    chk("rst_cnt", 32'(snooze_cnt), 32'd0);
    chk("rst_target", 32'({THT, THU, TMT, TMU}), 32'd0);
    tick();
    rst = 1'b1;

    // Alarm 07:30 triggers one cycle after the clock reaches it, then blinks
    setup(7*60+30, 7*60+29);
    chk("idle_target", 32'({THT, THU, TMT, TMU}), 32'(bcd(7*60+30)));
    chk("idle_quiet", 32'(ringing), 32'd0);
    set_clk(7*60+30);
    tick();
    chk("trig_ring", 32'(ringing), 32'd1);
    chk("trig_led", 32'(led_alarm), 32'd1);
    ring_window(29, -1);
    pulse(1'b1, 1'b0);
    chk("dismiss_ring", 32'(ringing), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_retrigger", 32'(ringing), 32'd0);
    end

    // Alarm 00:00 never rings
    setup(0, 1439);
    set_clk(0);
    tick();
    chk("zero_alarm", 32'(ringing), 32'd0);
    tick();
    chk("zero_alarm2", 32'(ringing), 32'd0);

    // 23:58 with three snoozes then a fourth that dismisses
    cur = 23*60+58;
    setup(cur, cur - 1);
    set_clk(cur);
    tick();
    chk("ring_2358", 32'(ringing), 32'd1);
    for (int i = 0; i < MAXS; i++) begin
      pulse(1'b0, 1'b1);
      chk("snz_ring", 32'(ringing), 32'd0);
      chk("snz_flag", 32'(snoozed), 32'd1);
      chk("snz_cnt", 32'(snooze_cnt), 32'(i + 1));
      tick();
      cur = (cur + SNZ) % 1440;
      chk("snz_target", 32'({THT, THU, TMT, TMU}), 32'(bcd(cur)));
      set_clk(cur);
      tick();
      chk("snz_rering", 32'(ringing), 32'd1);
      chk("snz_rering_flag", 32'(snoozed), 32'd0);
    end
    pulse(1'b0, 1'b1);
    chk("max_snz_ring", 32'(ringing), 32'd0);
    chk("max_snz_flag", 32'(snoozed), 32'd0);
    chk("max_snz_cnt", 32'(snooze_cnt), 32'd0);

    // Dismiss and snooze together: dismiss wins
    setup(23*60+58, 23*60+57);
    set_clk(23*60+58);
    tick();
    chk("both_pre", 32'(ringing), 32'd1);
    pulse(1'b1, 1'b1);
    chk("both_ring", 32'(ringing), 32'd0);
    chk("both_snz", 32'(snoozed), 32'd0);
    chk("both_cnt", 32'(snooze_cnt), 32'd0);

    // en dropped while ringing
    setup(23*60+58, 23*60+57);
    set_clk(23*60+58);
    tick();
    chk("en_pre", 32'(ringing), 32'd1);
    en = 1'b0;
    tick();
    chk("en_drop", 32'(ringing), 32'd0);

    // Long ring without buttons: timeout only when configured
    setup(12*60+0, 11*60+59);
    set_clk(12*60+0);
    tick();
    chk("long_pre", 32'(ringing), 32'd1);
`ifdef ALARM_AUTO_TIMEOUT_EN
    drop = 2 * CLK_HZ;
`else
    drop = -1;
`endif
    ring_window(1000, drop);
    pulse(1'b1, 1'b0);

    // Randomized alarm times: trigger, snooze target arithmetic, then dismiss or alarm edit
    for (int r = 0; r < 10; r++) begin
      a = int'($urandom_range(1, 1439));
      setup(a, a - 1);
      set_clk(a);
      tick();
      chk("rnd_ring", 32'(ringing), 32'd1);
      pulse(1'b0, 1'b1);
      chk("rnd_snz", 32'(snoozed), 32'd1);
      tick();
      chk("rnd_target", 32'({THT, THU, TMT, TMU}), 32'(bcd((a + SNZ) % 1440)));
      if ($urandom_range(0, 1) == 0) begin
        pulse(1'b1, 1'b0);
      end else begin
        set_alm((a % 1439) + 1);
        tick();
      end
      chk("rnd_cancel", 32'(snoozed), 32'd0);
      chk("rnd_cancel_ring", 32'(ringing), 32'd0);
    end

    // Asynchronous reset in the middle of a snooze
    setup(6*60+0, 5*60+59);
    set_clk(6*60+0);
    tick();
    pulse(1'b0, 1'b1);
    tick();
    chk("pre_rst_snz", 32'(snoozed), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ringing", 32'(ringing), 32'd0);
    chk("arst_snoozed", 32'(snoozed), 32'd0);
    chk("arst_cnt", 32'(snooze_cnt), 32'd0);
    chk("arst_led", 32'(led_alarm), 32'd0);
    chk("arst_target", 32'({THT, THU, TMT, TMU}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
